rob_nwide: RTL

- Parametrised N-wide reorder buffer for the R10K-style out-of-order core. Successor to the 2-wide ROB.
- Circular buffer with head and tail pointers, sitting between dispatch (rename) and the retire/free-list logic.
- Adds the following over the previous generation:
  - free-slot backpressure;
  - completion by ROB index instead of an associative tag search;
  - correct wrap-around count arithmetic;
  - in-order multi-retire that stops at the first incomplete entry;
  - retire-time mispredict squash that flushes all younger entries.

---
 rtl/rob_pkg.sv | 33 +++
 rtl/rob_retire_select.sv | 37 +++
 rtl/rob_nwide.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// Shared defaults, derived widths and entry layout for the N-wide reorder buffer.
package rob_pkg;

  localparam int DEF_ROB_SIZE = 32;
  localparam int DEF_PRF_SIZE = 64;
  localparam int DEF_RF_SIZE  = 32;
  localparam int DEF_WIDTH    = 2;
  localparam int DEF_XLEN     = 32;

  localparam int DEF_IW = $clog2(DEF_ROB_SIZE);
  localparam int DEF_PW = $clog2(DEF_PRF_SIZE);
  localparam int DEF_AW = $clog2(DEF_RF_SIZE);
  localparam int DEF_CW = DEF_IW + 1;

  // Entry layout for the default configuration; the top re-derives it from its parameters.
  typedef struct packed {
    logic                valid;
    logic                complete;
    logic                mispredict;
    logic                is_branch;
    logic [DEF_AW-1:0]   rd;
    logic [DEF_PW-1:0]   t;
    logic [DEF_PW-1:0]   t_old;
    logic [DEF_XLEN-1:0] pc;
    logic [DEF_XLEN-1:0] target;
  } rob_entry_t;

  // Lane counts never exceed four, so a 4-bit popcount covers every WIDTH.
  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/rob_retire_select.sv
// In-order retire scan over the WIDTH entries starting at head; stops at the first
// incomplete entry and after the first mispredicted branch, which raises squash.
module rob_retire_select #(
  parameter int WIDTH = 2,
  parameter int XLEN  = 32
) (
  input  logic [WIDTH-1:0]      valid_i,
  input  logic [WIDTH-1:0]      complete_i,
  input  logic [WIDTH-1:0]      mispredict_i,
  input  logic [WIDTH*XLEN-1:0] target_i,
  output logic [WIDTH-1:0]      retire_o,
  output logic                  squash_o,
  output logic [XLEN-1:0]       squash_pc_o
);

  logic scan_open;

  always_comb begin
    retire_o    = '0;
    squash_o    = 1'b0;
    squash_pc_o = '0;
    scan_open   = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (scan_open && valid_i[i] && complete_i[i]) begin
        retire_o[i] = 1'b1;
        if (mispredict_i[i]) begin
          squash_o    = 1'b1;
          squash_pc_o = target_i[i*XLEN +: XLEN];
          scan_open   = 1'b0;
        end
      end else begin
        scan_open = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rob_nwide.sv
// N-wide circular reorder buffer: contiguous dispatch at tail, completion by index,
// in-order multi-retire from head and a full flush when a mispredicted branch retires.
module rob_nwide
  import rob_pkg::*;
#(
  parameter int ROB_SIZE       = DEF_ROB_SIZE,
  parameter int PRF_SIZE       = DEF_PRF_SIZE,
  parameter int RF_SIZE        = DEF_RF_SIZE,
  parameter int WIDTH          = DEF_WIDTH,
  parameter int XLEN           = DEF_XLEN,
  parameter bit CHECK_OVERFLOW = 1'b1,
  localparam int IW = $clog2(ROB_SIZE),
  localparam int PW = $clog2(PRF_SIZE),
  localparam int AW = $clog2(RF_SIZE),
  localparam int CW = IW + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      dispatch_en,
  input  logic [WIDTH*AW-1:0]   dispatch_rd,
  input  logic [WIDTH*PW-1:0]   dispatch_T,
  input  logic [WIDTH*PW-1:0]   dispatch_T_old,
  input  logic [WIDTH*XLEN-1:0] dispatch_pc,
  input  logic [WIDTH-1:0]      dispatch_is_branch,
  output logic [WIDTH*IW-1:0]   dispatch_idx,
  output logic [CW-1:0]         free_slots,
  input  logic [WIDTH-1:0]      complete_en,
  input  logic [WIDTH*IW-1:0]   complete_idx,
  input  logic [WIDTH-1:0]      complete_mispredict,
  input  logic [WIDTH*XLEN-1:0] complete_target,
  output logic [WIDTH-1:0]      retire_valid,
  output logic [WIDTH*PW-1:0]   retire_T,
  output logic [WIDTH*PW-1:0]   retire_T_old,
  output logic [WIDTH*AW-1:0]   retire_rd,
  output logic                  squash,
  output logic [XLEN-1:0]       squash_pc,
  output logic                  empty
);

  typedef struct packed {
    logic            valid;
    logic            complete;
    logic            mispredict;
    logic            is_branch;
    logic [AW-1:0]   rd;
    logic [PW-1:0]   t;
    logic [PW-1:0]   t_old;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
  } entry_t;

  entry_t        ent_q [ROB_SIZE];
  entry_t        ent_d [ROB_SIZE];
  logic [IW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [WIDTH-1:0]      disp_acc, disp_drop;
  logic [2:0]            num_disp, num_ret;
  logic                  dispatch_overflow;
  logic [WIDTH*IW-1:0]   lane_idx;
  logic [WIDTH-1:0]      lane_valid, lane_complete, lane_mispredict;
  logic [WIDTH*XLEN-1:0] lane_target;

  assign free_slots = CW'(ROB_SIZE) - count_q;
  assign empty      = (count_q == '0);

  // Admission uses the start-of-cycle free count only; retire frees nothing until the edge.
  always_comb begin
    disp_acc  = '0;
    disp_drop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (dispatch_en[i]) begin
        if (CW'(i) < free_slots) disp_acc[i] = 1'b1;
        else                     disp_drop[i] = 1'b1;
      end
    end
  end

  assign num_disp          = popcount4(4'(disp_acc));
  assign num_ret           = popcount4(4'(retire_valid));
  assign dispatch_overflow = (|disp_drop) && !squash;

  always_comb begin
    lane_idx        = '0;
    lane_valid      = '0;
    lane_complete   = '0;
    lane_mispredict = '0;
    lane_target     = '0;
    dispatch_idx    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      lane_idx[i*IW +: IW]       = head_q + IW'(i);
      dispatch_idx[i*IW +: IW]   = tail_q + IW'(i);
      lane_valid[i]              = ent_q[lane_idx[i*IW +: IW]].valid;
      lane_complete[i]           = ent_q[lane_idx[i*IW +: IW]].complete;
      lane_mispredict[i]         = ent_q[lane_idx[i*IW +: IW]].mispredict
                                   && ent_q[lane_idx[i*IW +: IW]].is_branch;
      lane_target[i*XLEN +: XLEN] = ent_q[lane_idx[i*IW +: IW]].target;
    end
  end

  rob_retire_select #(
    .WIDTH (WIDTH),
    .XLEN  (XLEN)
  ) u_retire_select (
    .valid_i      (lane_valid),
    .complete_i   (lane_complete),
    .mispredict_i (lane_mispredict),
    .target_i     (lane_target),
    .retire_o     (retire_valid),
    .squash_o     (squash),
    .squash_pc_o  (squash_pc)
  );

  always_comb begin
    retire_T     = '0;
    retire_T_old = '0;
    retire_rd    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (retire_valid[i]) begin
        retire_T[i*PW +: PW]     = ent_q[lane_idx[i*IW +: IW]].t;
        retire_T_old[i*PW +: PW] = ent_q[lane_idx[i*IW +: IW]].t_old;
        retire_rd[i*AW +: AW]    = ent_q[lane_idx[i*IW +: IW]].rd;
      end
    end
  end

  // Order matters: retire clears, then completions land on still-valid entries, then dispatch writes.
  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (squash) begin
      for (int j = 0; j < ROB_SIZE; j++) begin
        ent_d[j].valid    = 1'b0;
        ent_d[j].complete = 1'b0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (retire_valid[i]) begin
          ent_d[lane_idx[i*IW +: IW]].valid    = 1'b0;
          ent_d[lane_idx[i*IW +: IW]].complete = 1'b0;
        end
      end
      for (int i = 0; i < WIDTH; i++) begin
        if (complete_en[i] && ent_d[complete_idx[i*IW +: IW]].valid) begin
          ent_d[complete_idx[i*IW +: IW]].complete   = 1'b1;
          ent_d[complete_idx[i*IW +: IW]].mispredict = complete_mispredict[i];
          ent_d[complete_idx[i*IW +: IW]].target     = complete_target[i*XLEN +: XLEN];
        end
      end
      for (int i = 0; i < WIDTH; i++) begin
        if (disp_acc[i]) begin
          ent_d[dispatch_idx[i*IW +: IW]].valid      = 1'b1;
          ent_d[dispatch_idx[i*IW +: IW]].complete   = 1'b0;
          ent_d[dispatch_idx[i*IW +: IW]].mispredict = 1'b0;
          ent_d[dispatch_idx[i*IW +: IW]].is_branch  = dispatch_is_branch[i];
          ent_d[dispatch_idx[i*IW +: IW]].rd         = dispatch_rd[i*AW +: AW];
          ent_d[dispatch_idx[i*IW +: IW]].t          = dispatch_T[i*PW +: PW];
          ent_d[dispatch_idx[i*IW +: IW]].t_old      = dispatch_T_old[i*PW +: PW];
          ent_d[dispatch_idx[i*IW +: IW]].pc         = dispatch_pc[i*XLEN +: XLEN];
          ent_d[dispatch_idx[i*IW +: IW]].target     = '0;
        end
      end
      head_d  = head_q + IW'(num_ret);
      tail_d  = tail_q + IW'(num_disp);
      count_d = count_q + CW'(num_disp) - CW'(num_ret);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int j = 0; j < ROB_SIZE; j++) ent_q[j] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ent_q   <= ent_d;
      if (CHECK_OVERFLOW) assert (!dispatch_overflow);
    end
  end

endmodule
